// File: rtl/mat_load_seq.sv
// mat_load_seq
// Front-end loader for the 4x64 complex matrix multiplier.
// Collects one frame of NSAMP complex (z,j) sample pairs over a valid/ready
// interface. It then replays the frame as 2*NSAMP indexed writes: real parts
// go to index 1..NSAMP and imaginary parts go to NSAMP+1..2*NSAMP. After the
// last write, index stays parked at 2*NSAMP until frame_start re-arms the loader.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   in_valid     input beat valid
//   in_ready     loader accepts a beat (FILL only)
//   in_z_re/im   z sample, real / imaginary part (DW bits, signed)
//   in_j_re/im   j sample, real / imaginary part (DW bits, signed)
//   in_last      marks the final beat of a frame
//   frame_start  pulse in DONE: start a new frame
//   index        write slot for the multiplier (0 = no write, 1..2*NSAMP)
//   a, b         z / j data for the current index, sign-extended to 32 bits
//   busy         high while draining
//   done         high once index is parked at 2*NSAMP
//   err_len      sticky in_last mismatch flag for the current frame
module mat_load_seq #(
   parameter int DW    = 16,
   parameter int NSAMP = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_z_re,
   input  logic [DW-1:0] in_z_im,
   input  logic [DW-1:0] in_j_re,
   input  logic [DW-1:0] in_j_im,
   input  logic          in_last,
   input  logic          frame_start,
   output logic [31:0]   index,
   output logic [31:0]   a,
   output logic [31:0]   b,
   output logic          busy,
   output logic          done,
   output logic          err_len
);

   localparam int AW = $clog2(NSAMP);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      FILL,
      DRAIN_RE,
      DRAIN_IM,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              armed;
   logic [AW-1:0]     wr_cnt;
   logic [CW-1:0]     rd_cnt;
   logic [4*DW-1:0]   mem [NSAMP];
   logic [4*DW-1:0]   ram_q;
   logic              p_valid;
   logic              p_im;
   logic [31:0]       p_idx;
   logic              beat;
   logic              issue;
   logic              restart;
   logic              last_out;

   function automatic logic [31:0] sext(input logic [DW-1:0] s);
      return {{(32-DW){s[DW-1]}}, s};
   endfunction

   // Next-state logic and state-decoded controls.
   // DRAIN_IM keeps running after its last read so that the final write can
   // leave the two-stage read pipeline. DONE is entered only when index
   // actually reaches 2*NSAMP.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      beat      = 1'b0;
      issue     = 1'b0;
      restart   = 1'b0;
      last_out  = p_valid && (p_idx == 32'(2*NSAMP));
      case (state)
         FILL: begin
            in_ready = armed;
            beat     = in_valid && armed;
            if (beat && (wr_cnt == AW'(NSAMP-1)))
               state_nxt = DRAIN_RE;
         end
         DRAIN_RE: begin
            busy  = 1'b1;
            issue = 1'b1;
            if (rd_cnt == CW'(NSAMP-1))
               state_nxt = DRAIN_IM;
         end
         DRAIN_IM: begin
            busy  = 1'b1;
            issue = (rd_cnt < CW'(NSAMP));
            if (last_out)
               state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (frame_start) begin
               restart   = 1'b1;
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   // State register.
   // armed holds in_ready low while reset is asserted and raises it from the
   // first clock after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
      end
   end

   // Write and read counters, plus the length-error flag.
   // rd_cnt has one extra bit so that DRAIN_IM can sit at NSAMP after its last read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         err_len <= 1'b0;
      end else begin
         if (restart)
            wr_cnt <= '0;
         else if (beat)
            wr_cnt <= wr_cnt + 1'b1;

         if (restart)
            rd_cnt <= '0;
         else if ((state == DRAIN_RE) && (rd_cnt == CW'(NSAMP-1)))
            rd_cnt <= '0;
         else if (issue)
            rd_cnt <= rd_cnt + 1'b1;

         if (restart)
            err_len <= 1'b0;
         else if (beat && (in_last != (wr_cnt == AW'(NSAMP-1))))
            err_len <= 1'b1;
      end
   end

   // Frame buffer: one write port, one synchronous read port, and no reset, so
   // that it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (beat)
         mem[wr_cnt] <= {in_z_re, in_z_im, in_j_re, in_j_im};
   end

   always_ff @(posedge clk) begin
      if (issue)
         ram_q <= mem[rd_cnt[AW-1:0]];
   end

   // Slot bookkeeping that travels alongside the RAM read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_valid <= 1'b0;
         p_im    <= 1'b0;
         p_idx   <= '0;
      end else begin
         p_valid <= issue;
         if (issue) begin
            p_im  <= (state == DRAIN_IM);
            p_idx <= ((state == DRAIN_IM) ? 32'(NSAMP) : 32'd0) + 32'(rd_cnt) + 32'd1;
         end
      end
   end

   // Output registers.
   // index, a and b update together, so the multiplier sees a consistent
   // slot on every index change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         index <= '0;
         a     <= '0;
         b     <= '0;
      end else if (restart) begin
         index <= '0;
      end else if (p_valid) begin
         index <= p_idx;
         a     <= p_im ? sext(ram_q[3*DW-1:2*DW]) : sext(ram_q[4*DW-1:3*DW]);
         b     <= p_im ? sext(ram_q[DW-1:0])      : sext(ram_q[2*DW-1:DW]);
      end
   end

endmodule

// File: tb/tb_mat_load_seq.sv
// tb_mat_load_seq
// Self-checking bench for mat_load_seq. It builds frames (ramp, random, and
// ramp+1) in plain arrays and pushes them through the ready/valid interface
// with random valid duty. It then checks every index/a/b write against those
// arrays. It also covers length errors, back-to-back frames, and an
// asynchronous reset in the middle of a drain.
module tb_mat_load_seq;

   localparam int DW    = 16;
   localparam int NSAMP = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          frame_start = 1'b0;
   logic [DW-1:0] in_z_re = '0;
   logic [DW-1:0] in_z_im = '0;
   logic [DW-1:0] in_j_re = '0;
   logic [DW-1:0] in_j_im = '0;
   logic          in_ready;
   logic [31:0]   index;
   logic [31:0]   a;
   logic [31:0]   b;
   logic          busy;
   logic          done;
   logic          err_len;

   int checkCount = 0;
   int passCount  = 0;

   // Reference frame, kept as signed samples; expectations sign-extend by plain assignment
   logic signed [DW-1:0] zr [NSAMP];
   logic signed [DW-1:0] zi [NSAMP];
   logic signed [DW-1:0] jr [NSAMP];
   logic signed [DW-1:0] ji [NSAMP];
   logic [31:0]          seenA [2*NSAMP+1];
   logic [31:0]          seenB [2*NSAMP+1];

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   mat_load_seq #(.DW(DW), .NSAMP(NSAMP)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_z_re     (in_z_re),
      .in_z_im     (in_z_im),
      .in_j_re     (in_j_re),
      .in_j_im     (in_j_im),
      .in_last     (in_last),
      .frame_start (frame_start),
      .index       (index),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .err_len     (err_len)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   // Fill the reference arrays: 0 = ramp, 1 = random with sign-extension corners, 2 = ramp+1
   task automatic makeFrame(input int mode);
      for (int k = 0; k < NSAMP; k++) begin
         case (mode)
            0: begin
               zr[k] = DW'(k);      zi[k] = DW'(-k);
               jr[k] = DW'(2*k);    ji[k] = DW'(k+1000);
            end
            1: begin
               zr[k] = DW'($urandom()); zi[k] = DW'($urandom());
               jr[k] = DW'($urandom()); ji[k] = DW'($urandom());
            end
            default: begin
               zr[k] = DW'(k+1);    zi[k] = DW'(-k+1);
               jr[k] = DW'(2*k+1);  ji[k] = DW'(k+1001);
            end
         endcase
      end
      if (mode == 1) begin
         zr[0] = 16'h8000;
         zr[1] = 16'h7FFF;
      end
   endtask

   // Push the reference frame with the given valid duty (percent).
   // in_last is raised on beat lastAt. The task returns at the negedge that
   // follows the edge which takes the final beat.
   task automatic applyStimulus(input int duty, input int lastAt);
      int k;
      int guard;
      k = 0;
      guard = 0;
      while (k < NSAMP && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (k == 0 && guard == 1)
            checkOutput("ready_in_fill", {31'd0, in_ready}, 32'd1);
         in_valid = ($urandom_range(99) < duty);
         in_z_re  = zr[k];
         in_z_im  = zi[k];
         in_j_re  = jr[k];
         in_j_im  = ji[k];
         in_last  = (k == lastAt);
         if (in_valid && in_ready)
            k++;
      end
      if (k < NSAMP)
         checkOutput("fill_timeout", 32'(k), 32'(NSAMP));
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Follow the drain cycle by cycle against the reference frame.
   // frame_start is pulsed at index fsAt, which should be ignored while
   // draining. An asynchronous reset is forced at index rstAt.
   task automatic drainCheck(input logic expErr, input int fsAt, input int rstAt);
      int n;
      int expA;
      int expB;
      n = 0;
      while (index == 32'd0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_latency", 32'(n), 32'd2);
      for (int i = 1; i <= 2*NSAMP; i++) begin
         if (i > 1)
            @(negedge clk);
         frame_start = (i == fsAt);
         if (i <= NSAMP) begin
            expA = zr[i-1];
            expB = jr[i-1];
         end else begin
            expA = zi[i-1-NSAMP];
            expB = ji[i-1-NSAMP];
         end
         checkOutput("index", index, 32'(i));
         checkOutput("a", a, 32'(expA));
         checkOutput("b", b, 32'(expB));
         seenA[i] = a;
         seenB[i] = b;
         if (i == NSAMP) begin
            checkOutput("busy_mid", {31'd0, busy}, 32'd1);
            checkOutput("ready_mid", {31'd0, in_ready}, 32'd0);
            checkOutput("done_mid", {31'd0, done}, 32'd0);
         end
         if (i == rstAt) begin
            #2 rst = 1'b0;
            #1;
            checkOutput("rst_index", index, 32'd0);
            checkOutput("rst_a", a, 32'd0);
            checkOutput("rst_b", b, 32'd0);
            checkOutput("rst_busy", {31'd0, busy}, 32'd0);
            checkOutput("rst_done", {31'd0, done}, 32'd0);
            checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
            return;
         end
      end
      frame_start = 1'b0;
      checkOutput("done_end", {31'd0, done}, 32'd1);
      checkOutput("busy_end", {31'd0, busy}, 32'd0);
      checkOutput("err_len", {31'd0, err_len}, {31'd0, expErr});
   endtask

   // In DONE: check that index and data hold, then pulse frame_start and
   // check that the loader is re-armed.
   task automatic startNext();
      @(negedge clk);
      checkOutput("hold_index", index, 32'(2*NSAMP));
      checkOutput("hold_a", a, seenA[2*NSAMP]);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      checkOutput("restart_index", index, 32'd0);
      checkOutput("restart_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("restart_done", {31'd0, done}, 32'd0);
      checkOutput("restart_err", {31'd0, err_len}, 32'd0);
   endtask

   // Watchdog so that a stuck design still produces a verdict
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence of scenarios
   initial begin
      repeat (2) @(negedge clk);
      checkOutput("reset_index", index, 32'd0);
      checkOutput("reset_a", a, 32'd0);
      checkOutput("reset_b", b, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_err", {31'd0, err_len}, 32'd0);
      checkOutput("reset_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("release_ready", {31'd0, in_ready}, 32'd0);

      $display("[TB] ramp frame");
      makeFrame(0);
      applyStimulus(100, NSAMP-1);
      drainCheck(1'b0, 0, 0);
      checkOutput("ramp_a1", seenA[1], 32'd0);
      checkOutput("ramp_a256", seenA[256], 32'd255);
      checkOutput("ramp_a257", seenA[257], 32'd0);
      checkOutput("ramp_a512", seenA[512], 32'hFFFFFF01);
      checkOutput("ramp_b512", seenB[512], 32'd1255);
      startNext();

      $display("[TB] sign extension frame");
      makeFrame(1);
      applyStimulus(100, NSAMP-1);
      drainCheck(1'b0, 0, 0);
      checkOutput("sext_min", seenA[1], 32'hFFFF8000);
      checkOutput("sext_max", seenA[2], 32'h00007FFF);
      startNext();

      $display("[TB] bursty ramp frame");
      makeFrame(0);
      applyStimulus(30, NSAMP-1);
      drainCheck(1'b0, 0, 0);
      startNext();

      $display("[TB] early in_last");
      makeFrame(1);
      applyStimulus(80, 100);
      drainCheck(1'b1, 0, 0);
      startNext();

      $display("[TB] missing in_last");
      makeFrame(1);
      applyStimulus(70, -1);
      drainCheck(1'b1, 0, 0);
      startNext();

      $display("[TB] back-to-back with stray frame_start");
      makeFrame(2);
      applyStimulus(100, NSAMP-1);
      drainCheck(1'b0, 50, 0);
      startNext();

      $display("[TB] async reset mid-drain");
      makeFrame(1);
      applyStimulus(100, NSAMP-1);
      drainCheck(1'b0, 0, 300);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rerelease_ready", {31'd0, in_ready}, 32'd0);
      makeFrame(2);
      applyStimulus(60, NSAMP-1);
      drainCheck(1'b0, 0, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
